// File: rtl/risc16b_boot_ctrl.sv
// Boot controller for the risc16b core: host program load, run supervision and drain.
// Define RISC16B_BOOT_CTRL_TIMEOUT_EN to enable the cycle_limit run timeout.
module risc16b_boot_ctrl #(
    parameter int CNT_W     = 32,
    parameter int DRAIN_CYC = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             host_valid,
    output logic             host_ready,
    input  logic [15:0]      host_addr,
    input  logic [15:0]      host_data,
    input  logic             host_start,
    input  logic             host_clear,
    input  logic [15:0]      halt_addr,
    input  logic [CNT_W-1:0] cycle_limit,
    output logic [15:0]      imem_addr,
    output logic [15:0]      imem_din,
    output logic [1:0]       imem_we,
    output logic             cpu_rst,
    input  logic [15:0]      cpu_i_addr,
    output logic             busy,
    output logic             done,
    output logic             timeout,
    output logic [CNT_W-1:0] cycle_count
);

    localparam int DW = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;
    localparam logic [DW-1:0]    DRAIN_LAST = DW'(DRAIN_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_MAX    = '1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             timeout_q, timeout_d;
    logic [DW-1:0]    drain_q, drain_d;
    logic             we_q, we_d;
    logic [15:0]      waddr_q, waddr_d;
    logic [15:0]      wdata_q, wdata_d;
    logic             load_fire;
    logic             halt_hit;
    logic             limit_hit;

    // Writes are always word-aligned, so the low address bit never matters.
    logic unused_addr0;
    assign unused_addr0 = host_addr[0];

`ifdef RISC16B_BOOT_CTRL_TIMEOUT_EN
    assign limit_hit = (cycle_limit != '0) && (cnt_q == cycle_limit);
`else
    logic unused_limit;
    assign unused_limit = ^cycle_limit;
    assign limit_hit    = 1'b0;
`endif

    assign load_fire = host_valid && (state_q == S_IDLE);
    assign halt_hit  = (cpu_i_addr == halt_addr);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        timeout_d = timeout_q;
        drain_d   = drain_q;
        we_d      = load_fire;
        waddr_d   = load_fire ? {host_addr[15:1], 1'b0} : waddr_q;
        wdata_d   = load_fire ? host_data : wdata_q;

        case (state_q)
            S_IDLE: begin
                if (host_start) begin
                    state_d   = S_RUN;
                    cnt_d     = '0;
                    timeout_d = 1'b0;
                end
            end
            S_RUN: begin
                // A halt match takes priority over a simultaneous limit hit.
                if (halt_hit) begin
                    state_d = S_DRAIN;
                    drain_d = '0;
                end else if (limit_hit) begin
                    state_d   = S_DONE;
                    timeout_d = 1'b1;
                end else if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DRAIN: begin
                if (drain_q == DRAIN_LAST) begin
                    state_d = S_DONE;
                end else begin
                    drain_d = drain_q + 1'b1;
                end
            end
            S_DONE: begin
                if (host_clear) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            timeout_q <= 1'b0;
            drain_q   <= '0;
            we_q      <= 1'b0;
            waddr_q   <= '0;
            wdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
            drain_q   <= drain_d;
            we_q      <= we_d;
            waddr_q   <= waddr_d;
            wdata_q   <= wdata_d;
        end
    end

    assign host_ready  = (state_q == S_IDLE);
    assign cpu_rst     = (state_q == S_IDLE);
    assign busy        = (state_q == S_RUN) || (state_q == S_DRAIN);
    assign done        = (state_q == S_DONE);
    assign timeout     = timeout_q;
    assign cycle_count = cnt_q;
    assign imem_we     = {2{we_q}};
    assign imem_addr   = waddr_q;
    assign imem_din    = wdata_q;

endmodule

// File: tb/tb_risc16b_boot_ctrl.sv
// Randomized self-checking bench for risc16b_boot_ctrl against a run-outcome model.
module tb_risc16b_boot_ctrl;

    localparam int CNT_W     = 8;
    localparam int DRAIN_CYC = 3;
    localparam int CNT_MAX   = (1 << CNT_W) - 1;
`ifdef RISC16B_BOOT_CTRL_TIMEOUT_EN
    localparam bit LIMIT_EN = 1'b1;
`else
    localparam bit LIMIT_EN = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             host_valid = 1'b0;
    logic             host_ready;
    logic [15:0]      host_addr = '0;
    logic [15:0]      host_data = '0;
    logic             host_start = 1'b0;
    logic             host_clear = 1'b0;
    logic [15:0]      halt_addr = '0;
    logic [CNT_W-1:0] cycle_limit = '0;
    logic [15:0]      imem_addr;
    logic [15:0]      imem_din;
    logic [1:0]       imem_we;
    logic             cpu_rst;
    logic [15:0]      cpu_i_addr = 16'hFFFF;
    logic             busy;
    logic             done;
    logic             timeout;
    logic [CNT_W-1:0] cycle_count;

    int n_checks = 0;
    int n_fail   = 0;

    risc16b_boot_ctrl #(.CNT_W(CNT_W), .DRAIN_CYC(DRAIN_CYC)) dut (
        .clk(clk), .rst(rst),
        .host_valid(host_valid), .host_ready(host_ready),
        .host_addr(host_addr), .host_data(host_data),
        .host_start(host_start), .host_clear(host_clear),
        .halt_addr(halt_addr), .cycle_limit(cycle_limit),
        .imem_addr(imem_addr), .imem_din(imem_din), .imem_we(imem_we),
        .cpu_rst(cpu_rst), .cpu_i_addr(cpu_i_addr),
        .busy(busy), .done(done), .timeout(timeout), .cycle_count(cycle_count)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        n_checks++; if ({host_ready, cpu_rst, busy, done, timeout} !== 5'b11000) begin n_fail++; $display("FAIL reset_ctrl: got rdy/crst/busy/done/to=%b want 11000", {host_ready, cpu_rst, busy, done, timeout}); end
        n_checks++; if (imem_we !== 2'b00 || imem_addr !== 16'h0 || imem_din !== 16'h0) begin n_fail++; $display("FAIL reset_imem: got we=%b addr=%h din=%h want 00/0000/0000", imem_we, imem_addr, imem_din); end
        n_checks++; if (cycle_count !== '0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", cycle_count); end
    endtask

    task automatic test_load();
        logic        prev_v;
        logic [15:0] prev_a, prev_d;
        host_valid = 1'b1; host_addr = 16'h0000; host_data = 16'h1234;
        step();
        n_checks++; if (imem_we !== 2'b11 || imem_addr !== 16'h0000 || imem_din !== 16'h1234) begin n_fail++; $display("FAIL load_w0: got we=%b addr=%h din=%h want 11/0000/1234", imem_we, imem_addr, imem_din); end
        host_addr = 16'h0003; host_data = 16'hABCD;
        step();
        n_checks++; if (imem_we !== 2'b11 || imem_addr !== 16'h0002 || imem_din !== 16'hABCD) begin n_fail++; $display("FAIL load_w1: got we=%b addr=%h din=%h want 11/0002/abcd", imem_we, imem_addr, imem_din); end
        host_valid = 1'b0;
        step();
        n_checks++; if (imem_we !== 2'b00) begin n_fail++; $display("FAIL load_idle_we: got %b want 00", imem_we); end
        prev_v = 1'b0; prev_a = '0; prev_d = '0;
        for (int i = 0; i < 24; i++) begin
            host_valid = 1'($urandom_range(0, 1));
            host_addr  = 16'($urandom);
            host_data  = 16'($urandom);
            prev_v = host_valid;
            prev_a = host_addr & 16'hFFFE;
            prev_d = host_data;
            step();
            n_checks++; if (imem_we !== {2{prev_v}}) begin n_fail++; $display("FAIL load_rand_we: got %b want %b", imem_we, {2{prev_v}}); end
            if (prev_v) begin
                n_checks++; if (imem_addr !== prev_a || imem_din !== prev_d) begin n_fail++; $display("FAIL load_rand_data: got %h/%h want %h/%h", imem_addr, imem_din, prev_a, prev_d); end
            end
        end
        host_valid = 1'b1; host_addr = 16'h5555; host_data = 16'h9999;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0; host_valid = 1'b0;
        n_checks++; if (imem_we !== 2'b00 || imem_addr !== 16'h0 || imem_din !== 16'h0) begin n_fail++; $display("FAIL load_rst_drop: got we=%b addr=%h din=%h want 00/0000/0000", imem_we, imem_addr, imem_din); end
    endtask

    task automatic test_start_with_load();
        logic [15:0] a, d;
        a = 16'($urandom); d = 16'($urandom);
        host_valid = 1'b1; host_addr = a; host_data = d; host_start = 1'b1;
        halt_addr = 16'h0100; cpu_i_addr = 16'h0000; cycle_limit = '0;
        step();
        host_valid = 1'b0; host_start = 1'b0;
        n_checks++; if (busy !== 1'b1 || cpu_rst !== 1'b0 || cycle_count !== '0) begin n_fail++; $display("FAIL start_load_state: got busy=%b crst=%b cnt=%0d want 1/0/0", busy, cpu_rst, cycle_count); end
        n_checks++; if (imem_we !== 2'b11 || imem_addr !== (a & 16'hFFFE) || imem_din !== d) begin n_fail++; $display("FAIL start_load_write: got we=%b %h/%h want 11 %h/%h", imem_we, imem_addr, imem_din, a & 16'hFFFE, d); end
        rst = 1'b1;
        host_valid = 1'b1; host_start = 1'b1;
        step();
        rst = 1'b0;
        n_checks++; if (busy !== 1'b0 || imem_we !== 2'b00 || host_ready !== 1'b1) begin n_fail++; $display("FAIL rst_start_load: got busy=%b we=%b rdy=%b want 0/00/1", busy, imem_we, host_ready); end
        host_valid = 1'b0; host_start = 1'b0;
    endtask

    // Outcome model: a run ends on the first halt match, or on the cycle whose
    // count equals a non-zero limit (timeout build only); halt wins a tie.
    task automatic run_program(input int halt_cyc, input int lim, input int max_cyc, input bit rst_in_drain);
        bit by_halt, by_lim;
        int end_cyc, exp_cnt;
        by_halt = (halt_cyc != 0) && (!LIMIT_EN || lim == 0 || halt_cyc <= lim + 1);
        by_lim  = !by_halt && LIMIT_EN && (lim != 0);
        end_cyc = by_halt ? halt_cyc : (by_lim ? lim + 1 : max_cyc);
        exp_cnt = by_halt ? halt_cyc - 1 : (by_lim ? lim : end_cyc);
        if (exp_cnt > CNT_MAX) exp_cnt = CNT_MAX;

        halt_addr   = 16'($urandom);
        cycle_limit = CNT_W'(lim);
        host_start  = 1'b1;
        step();
        host_start = 1'b0;
        for (int i = 1; i <= end_cyc; i++) begin
            cpu_i_addr = (i == halt_cyc) ? halt_addr : (halt_addr ^ 16'($urandom_range(1, 65535)));
            host_clear = 1'($urandom_range(0, 1));
            host_valid = 1'($urandom_range(0, 1));
            n_checks++; if ({busy, done, cpu_rst, host_ready} !== 4'b1000) begin n_fail++; $display("FAIL run_ctrl c%0d: got busy/done/crst/rdy=%b want 1000", i, {busy, done, cpu_rst, host_ready}); end
            n_checks++; if (int'(cycle_count) != ((i - 1 > CNT_MAX) ? CNT_MAX : i - 1) || imem_we !== 2'b00) begin n_fail++; $display("FAIL run_count c%0d: got cnt=%0d we=%b want %0d/00", i, cycle_count, imem_we, (i - 1 > CNT_MAX) ? CNT_MAX : i - 1); end
            step();
        end
        host_clear = 1'b0; host_valid = 1'b0;
        cpu_i_addr = halt_addr;
        n_checks++; if (int'(cycle_count) != exp_cnt) begin n_fail++; $display("FAIL run_final_count: got %0d want %0d", cycle_count, exp_cnt); end

        if (by_halt) begin
            for (int d = 1; d <= DRAIN_CYC; d++) begin
                if (rst_in_drain && d == 2) begin
                    rst = 1'b1;
                    step();
                    rst = 1'b0;
                    n_checks++; if ({busy, done, cpu_rst, host_ready} !== 4'b0011 || cycle_count !== '0) begin n_fail++; $display("FAIL drain_rst: got busy/done/crst/rdy=%b cnt=%0d want 0011/0", {busy, done, cpu_rst, host_ready}, cycle_count); end
                    return;
                end
                n_checks++; if ({busy, done, timeout} !== 3'b100 || int'(cycle_count) != exp_cnt) begin n_fail++; $display("FAIL drain_c%0d: got busy/done/to=%b cnt=%0d want 100/%0d", d, {busy, done, timeout}, cycle_count, exp_cnt); end
                step();
            end
        end

        if (by_halt || by_lim) begin
            n_checks++; if ({busy, done, cpu_rst, timeout} !== {3'b010, by_lim}) begin n_fail++; $display("FAIL done_state: got busy/done/crst/to=%b want %b", {busy, done, cpu_rst, timeout}, {3'b010, by_lim}); end
            host_start = 1'b1;
            step();
            host_start = 1'b0;
            n_checks++; if (done !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL done_ignore_start: got done=%b busy=%b want 1/0", done, busy); end
            host_clear = 1'b1;
            step();
            host_clear = 1'b0;
            n_checks++; if ({host_ready, cpu_rst, done, busy} !== 4'b1100) begin n_fail++; $display("FAIL clear_idle: got rdy/crst/done/busy=%b want 1100", {host_ready, cpu_rst, done, busy}); end
            n_checks++; if (int'(cycle_count) != exp_cnt || timeout !== by_lim) begin n_fail++; $display("FAIL clear_hold: got cnt=%0d to=%b want %0d/%b", cycle_count, timeout, exp_cnt, by_lim); end
        end else begin
            n_checks++; if ({busy, done, timeout} !== 3'b100) begin n_fail++; $display("FAIL still_running: got busy/done/to=%b want 100", {busy, done, timeout}); end
            rst = 1'b1;
            step();
            rst = 1'b0;
        end
    endtask

    task automatic test_halt();
        run_program(8, 0, 8, 1'b0);
        for (int k = 0; k < 6; k++) begin
            run_program(int'($urandom_range(1, 30)), int'($urandom_range(0, 40)), 60, 1'b0);
        end
    endtask

    task automatic test_limit();
        run_program(0, 5, 20, 1'b0);
        run_program(0, int'($urandom_range(1, 30)), 40, 1'b0);
    endtask

    task automatic test_halt_and_limit();
        run_program(6, 5, 20, 1'b0);
    endtask

    task automatic test_rst_drain();
        run_program(4, 0, 10, 1'b1);
    endtask

    task automatic test_saturate();
        run_program(0, 0, 300, 1'b0);
        run_program(280, 0, 300, 1'b0);
    endtask

    initial begin
        test_reset();
        test_load();
        test_start_with_load();
        test_halt();
        test_limit();
        test_halt_and_limit();
        test_rst_drain();
        test_saturate();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/risc16b_boot_ctrl.md
RISC16B_BOOT_CTRL -- requirements
Module: risc16b_boot_ctrl

Interface
REQ-001 The block SHALL have parameter CNT_W, default 32, meaning width of cycle counter and cycle limit.
REQ-002 The block SHALL have parameter DRAIN_CYC, default 3, meaning pipeline drain cycles after halt match.
REQ-003 The block SHALL use one clock, clk; reset rst is synchronous and active-high.
REQ-004 Ports, in order:
- clk  in  1  clock.
- rst  in  1  sync active-high reset.
- host_valid  in  1  load word offered.
- host_ready  out  1  load word accepted when high with host_valid.
- host_addr  in  16  byte address of load word.
- host_data  in  16  load word.
- host_start  in  1  start pulse.
- host_clear  in  1  return to IDLE from DONE.
- halt_addr  in  16  fetch address meaning program end.
- cycle_limit  in  CNT_W  run timeout; 0 = unlimited.
- imem_addr  out  16  instruction-memory write address.
- imem_din  out  16  instruction-memory write data.
- imem_we  out  2  byte-lane write enables.
- cpu_rst  out  1  CPU reset.
- cpu_i_addr  in  16  CPU fetch address.
- busy  out  1  high in RUN or DRAIN.
- done  out  1  high in DONE.
- timeout  out  1  DONE was reached by limit.
- cycle_count  out  CNT_W  RUN cycle count.

Function
REQ-005 States SHALL be IDLE, RUN, DRAIN, DONE; encoding is free.
REQ-006 IDLE: cpu_rst=1, host_ready=1; all other states: host_ready=0.
REQ-007 Handshake host_valid&&host_ready SHALL register addr/data; next cycle imem_we=2'b11, imem_addr={host_addr[15:1],1'b0}, imem_din=host_data; otherwise imem_we=2'b00.
REQ-008 Odd host_addr SHALL be silently aligned down (bit 0 forced 0).
REQ-009 IDLE with host_start=1 SHALL go to RUN next cycle; a load handshake in the same cycle SHALL still complete its write (imem_we in the first RUN cycle).
REQ-010 Entering RUN SHALL clear cycle_count and timeout; cpu_rst=0 in RUN, DRAIN, DONE.
REQ-011 RUN: cycle_count SHALL increment by 1 per clock, saturating at all-ones.
REQ-012 RUN with cpu_i_addr==halt_addr SHALL go to DRAIN; cycle_count frozen from that edge.
REQ-013 RUN with limit enabled, cycle_limit!=0, cycle_count==cycle_limit and no halt match SHALL go to DONE with timeout=1.
REQ-014 Halt match and limit hit in the same cycle: halt SHALL win (DRAIN, timeout stays 0).
REQ-015 DRAIN SHALL last exactly DRAIN_CYC cycles then go to DONE; limit is ignored in DRAIN.
REQ-016 DONE: CPU keeps running (self-loop at halt_addr expected); host_clear=1 SHALL go to IDLE, reasserting cpu_rst next cycle; cycle_count/timeout held until next RUN entry.
REQ-017 host_start outside IDLE and host_clear outside DONE SHALL be ignored.
REQ-018 busy, done SHALL be decoded from registered state (no combinational path from inputs).

Reset
REQ-019 rst SHALL force IDLE, cpu_rst=1, host_ready=1 next cycle, imem_we=2'b00, imem_addr=0, imem_din=0, cycle_count=0, timeout=0, busy=0, done=0.
REQ-020 rst during RUN/DRAIN SHALL abort immediately; a pending registered write SHALL be dropped.

Configuration
REQ-021 Macro RISC16B_BOOT_CTRL_TIMEOUT_EN defined: REQ-013 limit logic SHALL be present.
REQ-022 Macro undefined: cycle_limit SHALL be ignored, timeout tied 0, RUN exits only on halt match; ports unchanged.

Verification
REQ-023 Load words 0x0000<-0x1234, 0x0003<-0xABCD -> imem_we=11 writes at 0x0000 and 0x0002, one cycle after each handshake.
REQ-024 start, halt_addr=0x0010, cpu_i_addr reaches 0x0010 on 8th RUN cycle -> cycle_count=7, DRAIN 3 cycles, done=1, timeout=0.
REQ-025 With _EN, cycle_limit=5, halt never hit -> DONE after cycle_count=5, timeout=1; without _EN -> stays busy.
REQ-026 Halt match on same cycle cycle_count==cycle_limit -> DRAIN then DONE, timeout=0.
REQ-027 rst asserted in 2nd DRAIN cycle -> next cycle IDLE, cpu_rst=1, cycle_count=0; host_clear in DONE -> IDLE, host_ready=1.
